dbuf_rx_deglitch: RTL



---
 rtl/dbuf_rx_deglitch.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/dbuf_rx_deglitch.sv
// -----------------------------------------------------------------------------
// dbuf_rx_deglitch
//
// Receive-side companion to the digital buffer brick. An asynchronous input
// passes through a SYNC_STAGES-deep synchronizer. A counter-qualified
// deglitch FSM follows it. A new level is accepted only after FILT_CYCLES
// consecutive stable synchronized samples. Outputs are a clean level plus
// one-cycle rise/fall event pulses.
//
// Optional feature macro: DBUF_RX_GLITCH_CNT_EN
//   When defined, an 8-bit saturating count of aborted qualifications
//   (rejected transitions) is exported on glitch_cnt.
//
// Ports:
//   clk         in   core clock, rising edge
//   rst         in   synchronous reset, active-high
//   CELV        in   brick supply    (connectivity only)
//   CELG        in   brick ground    (connectivity only)
//   SUB         in   substrate       (connectivity only)
//   i           in   asynchronous digital input from buffer/pad
//   o           out  deglitched, synchronized level
//   rise        out  one-cycle pulse when o goes 0->1
//   fall        out  one-cycle pulse when o goes 1->0
//   busy        out  high while a level change is being qualified
//   glitch_cnt  out  [7:0] rejected-transition count (macro only)
// -----------------------------------------------------------------------------
module dbuf_rx_deglitch #(
  parameter int SYNC_STAGES = 2,   // legal 2..4
  parameter int FILT_W      = 4,
  parameter int FILT_CYCLES = 8,   // legal 1..(2^FILT_W - 1)
  parameter bit RST_VAL     = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       CELV,
  input  logic       CELG,
  input  logic       SUB,
  input  logic       i,
  output logic       o,
  output logic       rise,
  output logic       fall,
  output logic       busy
`ifdef DBUF_RX_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    QUAL_HI   = 2'd1,
    STABLE_HI = 2'd2,
    QUAL_LO   = 2'd3
  } state_t;

  localparam state_t             RST_STATE = RST_VAL ? STABLE_HI : STABLE_LO;
  localparam logic [FILT_W-1:0]  CNT_LAST  = FILT_W'(FILT_CYCLES - 1);
  localparam logic [FILT_W-1:0]  CNT_ONE   = FILT_W'(1);
  // With a single-sample filter there is nothing to qualify: accept directly.
  localparam bit                 SINGLE    = (FILT_CYCLES == 1);

  // ---------------------------------------------------------------------------
  // Synchronizer
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values and the shift chain cannot collapse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Deglitch FSM
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [FILT_W-1:0]  cnt_q,   cnt_d;
  logic               o_q,     o_d;
  logic               rise_q,  rise_d;
  logic               fall_q,  fall_d;
  logic               busy_q,  busy_d;
  logic               abort;

  // NOTE: every output of this block is given a default before the case so
  // no path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    o_d     = o_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    abort   = 1'b0;

    unique case (state_q)
      STABLE_LO: begin
        if (s) begin
          if (SINGLE) begin
            state_d = STABLE_HI;
            o_d     = 1'b1;
            rise_d  = 1'b1;
          end else begin
            state_d = QUAL_HI;
            cnt_d   = CNT_ONE;
          end
        end
      end
      QUAL_HI: begin
        if (!s) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          abort   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          o_d     = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!s) begin
          if (SINGLE) begin
            state_d = STABLE_LO;
            o_d     = 1'b0;
            fall_d  = 1'b1;
          end else begin
            state_d = QUAL_LO;
            cnt_d   = CNT_ONE;
          end
        end
      end
      QUAL_LO: begin
        if (s) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          abort   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          o_d     = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RST_STATE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d == QUAL_HI) || (state_d == QUAL_LO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      o_q     <= RST_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign o    = o_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = busy_q;

  // ---------------------------------------------------------------------------
  // Optional rejected-transition counter
  // ---------------------------------------------------------------------------
  // Supply pins carry no logic; they are folded into a sink so they stay
  // visible in the netlist without driving anything.
  logic unused_sink;

`ifdef DBUF_RX_GLITCH_CNT_EN
  logic [7:0] glitch_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_q <= '0;
    end else if (abort && (glitch_q != 8'hFF)) begin
      glitch_q <= glitch_q + 8'd1;
    end
  end

  assign glitch_cnt  = glitch_q;
  assign unused_sink = ^{CELV, CELG, SUB};
`else
  assign unused_sink = ^{CELV, CELG, SUB, abort};
`endif

endmodule
